alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width (>= 4, power of 2).
REQ-002 SHALL have parameter SHW = log2(WIDTH), default 4, meaning the shift-amount bits taken from input_B.
REQ-003 SHALL have port input_CLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port input_Reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port input_Start  in  1  one-cycle request; operands and opcode sampled on this edge.
REQ-006 SHALL have port input_A  in  WIDTH  operand A.
REQ-007 SHALL have port input_B  in  WIDTH  operand B.
REQ-008 SHALL have port input_ALUOp  in  4  operation code.
REQ-009 SHALL have port output_ALU  out  WIDTH  registered result (low half / quotient).
REQ-010 SHALL have port output_High  out  WIDTH  registered high product half / remainder, 0 for other ops.
REQ-011 SHALL have port output_Busy  out  1  high while a multi-cycle op runs.
REQ-012 SHALL have port output_Done  out  1  one-cycle pulse when results and flags are valid.
REQ-013 SHALL have port output_Zero, output_Negative, output_Carry, output_Overflow, output_DivZero  out  1 each  registered flags.

Function
REQ-014 Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sla (= sll), 1000 sra, 1001 2*(A+B), 1010 mul unsigned, 1011 div unsigned, 1100 pass B; others SHALL produce result 0 with all flags 0.
REQ-015 Single-cycle ops SHALL register result and flags on the Start edge, output_Done high the following cycle (latency 1).
REQ-016 mul SHALL be shift-add, one bit per cycle: Busy high for exactly WIDTH cycles after Start edge, Done pulses the cycle Busy falls; product {output_High, output_ALU}.
REQ-017 div SHALL be restoring, one quotient bit per cycle, same WIDTH-cycle timing; output_ALU = quotient, output_High = remainder.
REQ-018 div with B = 0 SHALL complete in 1 cycle: quotient all ones, remainder = A, output_DivZero = 1; DivZero SHALL be 0 for every other result.
REQ-019 State machine IDLE -> RUN (Start with mul/div, B != 0 for div) -> DONE (counter reaches WIDTH-1) -> IDLE; single-cycle ops go IDLE -> DONE -> IDLE.
REQ-020 Start while Busy or in DONE SHALL be ignored; outputs and running op unaffected.
REQ-021 Result and flag registers SHALL hold their values until the next accepted Start completes; they SHALL NOT change mid-RUN.
REQ-022 Zero = (output_ALU == 0); Negative = output_ALU[WIDTH-1]; both for all ops.
REQ-023 Carry: add = carry out of bit WIDTH-1; sub = borrow (A < B unsigned); 2*(A+B) = bit WIDTH of A+B OR bit WIDTH-1 of A+B; mul = (output_High != 0); else 0.
REQ-024 Overflow: signed overflow for add, sub and 2*(A+B) (signed result outside WIDTH range); else 0.
REQ-025 Shifts SHALL use input_B[SHW-1:0] only; sra SHALL replicate A[WIDTH-1].
REQ-026 Arithmetic SHALL be carried at WIDTH+1 bits internally; mul accumulator 2*WIDTH bits.

Reset
REQ-027 Asserting input_Reset_n low SHALL immediately force IDLE, counter 0, all outputs 0, including mid-RUN; the aborted op SHALL produce no Done.
REQ-028 First Start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Opcode constants, state encoding and the flag-bit ordering SHALL live in shared package alu_pkg, reused by the control unit.
REQ-030 Iterative multiply/divide datapath SHALL be sub-module alu_muldiv (start, op, operands, busy, done, hi/lo); single-cycle logic stays in alu_seq.

Verification (WIDTH=16)
REQ-031 add A=FFFF, B=0001 -> 1 cycle later Done, ALU=0000, Zero=1, Carry=1, Overflow=0.
REQ-032 add A=7FFF, B=0001 -> ALU=8000, Negative=1, Overflow=1, Carry=0; sub A=0003, B=0005 -> ALU=FFFE, Carry=1.
REQ-033 mul A=FFFF, B=FFFF -> Busy 16 cycles, Done on 17th edge, High=FFFE, ALU=0001, Carry=1; Start pulsed at cycle 5 ignored.
REQ-034 div A=0064, B=0007 -> after 16 cycles ALU=000E, High=0002; div A=1234, B=0000 -> 1 cycle, ALU=FFFF, High=1234, DivZero=1.
REQ-035 sra A=8000, B=0013 (shift 3) -> ALU=F000; srl same -> 1000; pass B=ABCD -> ABCD.
REQ-036 mul started, Reset_n low at cycle 8 -> outputs 0, no Done; new add 0002+0003 after release -> ALU=0005 in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, control-state encoding and flag ordering.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'h5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SLA  = 4'h7;
    localparam logic [OP_W-1:0] OP_SRA  = 4'h8;
    localparam logic [OP_W-1:0] OP_ADD2 = 4'h9;
    localparam logic [OP_W-1:0] OP_MUL  = 4'hA;
    localparam logic [OP_W-1:0] OP_DIV  = 4'hB;
    localparam logic [OP_W-1:0] OP_PASB = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Flag ordering, MSB first: {zero, negative, carry, overflow, divzero}
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic divzero;
    } alu_flags_t;

    // Ops that go through the iterative datapath (div by zero finishes at once)
    function automatic logic is_iterative(input logic [OP_W-1:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module alu_muldiv #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_hi_c,
    output logic [WIDTH-1:0] o_lo_c
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic             r_busy;
    logic             r_div;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // mul: {hi,lo} holds partial product with multiplier in lo; div: hi = remainder, lo = dividend/quotient
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : (WIDTH+1)'(0));
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_hi_nxt    = w_mul_sum[WIDTH:1];
        w_lo_nxt    = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            if (!w_div_diff[WIDTH]) begin
                w_hi_nxt = w_div_diff[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_div_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_div  <= i_div;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= i_div ? i_a : i_b;
            r_opnd <= i_div ? i_b : i_a;
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + SHW'(1);
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done_c = r_busy && (r_cnt == CNT_LAST);
    assign o_hi_c   = w_hi_nxt;
    assign o_lo_c   = w_lo_nxt;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative mul/div with a start/busy/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             input_CLK,
    input  logic             input_Reset_n,
    input  logic             input_Start,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [3:0]       input_ALUOp,
    output logic [WIDTH-1:0] output_ALU,
    output logic [WIDTH-1:0] output_High,
    output logic             output_Busy,
    output logic             output_Done,
    output logic             output_Zero,
    output logic             output_Negative,
    output logic             output_Carry,
    output logic             output_Overflow,
    output logic             output_DivZero
);

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_alu;
    logic [WIDTH-1:0] r_high;
    alu_flags_t       r_flags;
    logic             r_done;
    logic             r_md_div;

    logic             w_iter;
    logic             w_accept;
    logic             w_md_start;
    logic             w_load_single;
    logic             w_load_md;

    logic             w_md_busy;
    logic             w_md_done_c;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;

    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_usum;
    logic [WIDTH:0]   w_udiff;
    logic             w_sum_sign;
    logic             w_known;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    alu_flags_t       w_fl;

    assign w_iter = is_iterative(input_ALUOp, input_B == '0);

    // State register
    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (input_Start) w_state_nxt = w_iter ? ST_RUN : ST_DONE;
            ST_RUN:  if (w_md_done_c) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        w_accept      = 1'b0;
        w_md_start    = 1'b0;
        w_load_single = 1'b0;
        w_load_md     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept      = input_Start;
                w_md_start    = input_Start && w_iter;
                w_load_single = input_Start && !w_iter;
            end
            ST_RUN:  w_load_md = w_md_done_c;
            default: ;
        endcase
    end

    alu_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk      (input_CLK),
        .rst_n    (input_Reset_n),
        .i_start  (w_md_start),
        .i_div    (input_ALUOp == OP_DIV),
        .i_a      (input_A),
        .i_b      (input_B),
        .o_busy   (w_md_busy),
        .o_done_c (w_md_done_c),
        .o_hi_c   (w_md_hi),
        .o_lo_c   (w_md_lo)
    );

    // Single-cycle datapath, arithmetic carried at WIDTH+1 bits
    always_comb begin
        w_sh       = input_B[SHW-1:0];
        w_usum     = {1'b0, input_A} + {1'b0, input_B};
        w_udiff    = {1'b0, input_A} - {1'b0, input_B};
        w_sum_sign = input_A[WIDTH-1] ^ input_B[WIDTH-1] ^ w_usum[WIDTH];
        w_known    = 1'b1;
        w_res      = '0;
        w_hi       = '0;
        w_fl       = '0;
        case (input_ALUOp)
            OP_ADD: begin
                w_res       = w_usum[WIDTH-1:0];
                w_fl.carry  = w_usum[WIDTH];
                w_fl.overflow = (input_A[WIDTH-1] == input_B[WIDTH-1]) &&
                                (w_usum[WIDTH-1] != input_A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res       = w_udiff[WIDTH-1:0];
                w_fl.carry  = w_udiff[WIDTH];
                w_fl.overflow = (input_A[WIDTH-1] != input_B[WIDTH-1]) &&
                                (w_udiff[WIDTH-1] != input_A[WIDTH-1]);
            end
            OP_AND:         w_res = input_A & input_B;
            OP_OR:          w_res = input_A | input_B;
            OP_XOR:         w_res = input_A ^ input_B;
            OP_SLL, OP_SLA: w_res = input_A << w_sh;
            OP_SRL:         w_res = input_A >> w_sh;
            OP_SRA:         w_res = WIDTH'($signed(input_A) >>> w_sh);
            OP_ADD2: begin
                // 2*(A+B) fits only if the top three bits of the signed sum agree
                w_res       = {w_usum[WIDTH-2:0], 1'b0};
                w_fl.carry  = w_usum[WIDTH] | w_usum[WIDTH-1];
                w_fl.overflow = !((w_sum_sign == w_usum[WIDTH-1]) &&
                                  (w_usum[WIDTH-1] == w_usum[WIDTH-2]));
            end
            OP_DIV: begin
                w_res        = '1;
                w_hi         = input_A;
                w_fl.divzero = 1'b1;
            end
            OP_PASB:        w_res = input_B;
            default:        w_known = 1'b0;
        endcase
        w_fl.zero     = w_known && (w_res == '0);
        w_fl.negative = w_known && w_res[WIDTH-1];
    end

    // Result/flag registers only change when an accepted op completes
    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            r_alu    <= '0;
            r_high   <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            r_md_div <= 1'b0;
        end else begin
            r_done <= w_load_single || w_load_md;
            if (w_md_start) begin
                r_md_div <= (input_ALUOp == OP_DIV);
            end
            if (w_load_single) begin
                r_alu   <= w_res;
                r_high  <= w_hi;
                r_flags <= w_fl;
            end else if (w_load_md) begin
                r_alu            <= w_md_lo;
                r_high           <= w_md_hi;
                r_flags          <= '0;
                r_flags.zero     <= (w_md_lo == '0);
                r_flags.negative <= w_md_lo[WIDTH-1];
                r_flags.carry    <= !r_md_div && (w_md_hi != '0);
            end
        end
    end

    assign output_ALU      = r_alu;
    assign output_High     = r_high;
    assign output_Busy     = w_md_busy;
    assign output_Done     = r_done;
    assign output_Zero     = r_flags.zero;
    assign output_Negative = r_flags.negative;
    assign output_Carry    = r_flags.carry;
    assign output_Overflow = r_flags.overflow;
    assign output_DivZero  = r_flags.divzero;

    logic w_unused;
    assign w_unused = w_accept;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [3:0]   op    = '0;

    logic [W-1:0] alu, high;
    logic         busy, done, z, n, c, v, dz;
    logic [4:0]   fl;

    int n_checks = 0;
    int n_err    = 0;

    assign fl = {z, n, c, v, dz};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SHW(4)) dut (
        .input_CLK       (clk),
        .input_Reset_n   (rst_n),
        .input_Start     (start),
        .input_A         (a),
        .input_B         (b),
        .input_ALUOp     (op),
        .output_ALU      (alu),
        .output_High     (high),
        .output_Busy     (busy),
        .output_Done     (done),
        .output_Zero     (z),
        .output_Negative (n),
        .output_Carry    (c),
        .output_Overflow (v),
        .output_DivZero  (dz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Single-cycle op: results one edge after Start, then Done drops
    task automatic single(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] e_alu,
                          input logic [W-1:0] e_high, input logic [4:0] e_fl);
        go(o, av, bv);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_alu"},  32'(alu),  32'(e_alu));
        chk({tag, "_high"}, 32'(high), 32'(e_high));
        chk({tag, "_flags"}, 32'(fl),  32'(e_fl));
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    // Iterative op: busy for 16 cycles, outputs held, optional ignored Start at cycle 5
    task automatic iter(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] hold_alu,
                        input logic [W-1:0] hold_high, input logic inject);
        go(o, av, bv);
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_done0"}, 32'(done), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            if (inject && i == 5) begin
                op = OP_ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
            end
            tick();
            start = 1'b0;
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), (i < 16) ? 32'd1 : 32'd0);
            chk($sformatf("%s_done%0d", tag, i), 32'(done), (i == 16) ? 32'd1 : 32'd0);
            if (i < 16) begin
                chk($sformatf("%s_hold_alu%0d", tag, i),  32'(alu),  32'(hold_alu));
                chk($sformatf("%s_hold_high%0d", tag, i), 32'(high), 32'(hold_high));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_alu",   32'(alu),  32'h0);
        chk("rst_high",  32'(high), 32'h0);
        chk("rst_bd",    32'({busy, done}), 32'h0);
        chk("rst_flags", 32'(fl),   32'h0);
        rst_n = 1'b1;

        // First Start right after release
        single("add_wrap", OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10100);
        single("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b01010);
        single("sub_brw",  OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 5'b01100);
        single("sra",      OP_SRA,  16'h8000, 16'h0013, 16'hF000, 16'h0000, 5'b01000);
        single("srl",      OP_SRL,  16'h8000, 16'h0013, 16'h1000, 16'h0000, 5'b00000);
        single("sla",      OP_SLA,  16'h0101, 16'h00F4, 16'h1010, 16'h0000, 5'b00000);
        single("passb",    OP_PASB, 16'h0000, 16'hABCD, 16'hABCD, 16'h0000, 5'b01000);
        single("add2_ovf", OP_ADD2, 16'h4000, 16'h0000, 16'h8000, 16'h0000, 5'b01010);
        single("add2_cy",  OP_ADD2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10100);
        single("xor",      OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 5'b00000);

        // Start in DONE is ignored
        go(OP_ADD, 16'h0001, 16'h0001);
        chk("add_11", 32'(alu), 32'h0002);
        go(OP_ADD, 16'h0005, 16'h0005);
        chk("ign_done_done", 32'(done), 32'd0);
        chk("ign_done_alu",  32'(alu),  32'h0002);

        single("bad_op", 4'hF, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b00000);

        // mul with ignored Start mid-run
        iter("mul", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        chk("mul_alu",   32'(alu),  32'h0001);
        chk("mul_high",  32'(high), 32'hFFFE);
        chk("mul_flags", 32'(fl),   32'(5'b00100));
        tick();
        chk("mul_done_drop", 32'(done), 32'd0);

        iter("div", OP_DIV, 16'h0064, 16'h0007, 16'h0001, 16'hFFFE, 1'b0);
        chk("div_alu",   32'(alu),  32'h000E);
        chk("div_high",  32'(high), 32'h0002);
        chk("div_flags", 32'(fl),   32'(5'b00000));
        tick();

        single("div0", OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 5'b01001);

        // Reset mid-run aborts with no Done
        go(OP_MUL, 16'h0003, 16'h0005);
        for (int i = 1; i <= 7; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("abort_alu",   32'(alu),  32'h0);
        chk("abort_high",  32'(high), 32'h0);
        chk("abort_bd",    32'({busy, done}), 32'h0);
        chk("abort_flags", 32'(fl),   32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), 32'({busy, done}), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk($sformatf("post_rst_idle%0d", i), 32'({busy, done}), 32'h0);
        end
        single("add_post", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 5'b00000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
